// File: rtl/ex_operand_bypass_if.sv
// ID/EX bypass stage bundle: decoded ID operands, EX/MEM and MEM/WB writeback
// taps, and the EX-side operands, control and hazard outputs.
interface ex_operand_bypass_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic [RA_W-1:0]  id_rs;
  logic [RA_W-1:0]  id_rt;
  logic [RA_W-1:0]  id_rd;
  logic [WIDTH-1:0] id_rs_data;
  logic [WIDTH-1:0] id_rt_data;
  logic [WIDTH-1:0] id_imm;
  logic [1:0]       id_reg_dst;
  logic             id_alu_src;
  logic             id_mem_read;
  logic             id_reg_write;
  logic             flush;

  logic             mem_reg_write;
  logic [RA_W-1:0]  mem_dst;
  logic [WIDTH-1:0] mem_data;
  logic             wb_reg_write;
  logic [RA_W-1:0]  wb_dst;
  logic [WIDTH-1:0] wb_data;

  logic             ex_valid;
  logic [WIDTH-1:0] ex_op_a;
  logic [WIDTH-1:0] ex_op_b;
  logic [WIDTH-1:0] ex_store_data;
  logic [RA_W-1:0]  ex_dst;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic             stall;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_reg_dst, id_alu_src, id_mem_read, id_reg_write, flush,
           mem_reg_write, mem_dst, mem_data, wb_reg_write, wb_dst, wb_data,
    input  ex_valid, ex_op_a, ex_op_b, ex_store_data, ex_dst, ex_reg_write,
           ex_mem_read, stall, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_reg_dst, id_alu_src, id_mem_read, id_reg_write, flush,
           mem_reg_write, mem_dst, mem_data, wb_reg_write, wb_dst, wb_data,
    output ex_valid, ex_op_a, ex_op_b, ex_store_data, ex_dst, ex_reg_write,
           ex_mem_read, stall, stall_cnt
  );
endinterface

// File: rtl/ex_operand_bypass.sv
// ID/EX stage register with destination resolve, EX/MEM and MEM/WB operand
// bypass, immediate select, load-use bubble insertion and a stall counter.
module ex_operand_bypass #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned RA_W     = 5,
  parameter int unsigned LINK_REG = 31,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ex_operand_bypass_if.slave   bus
);

  localparam logic [RA_W-1:0] LINK_IDX = RA_W'(LINK_REG);

  logic             valid_q;
  logic [RA_W-1:0]  rs_q;
  logic [RA_W-1:0]  rt_q;
  logic [WIDTH-1:0] rs_data_q;
  logic [WIDTH-1:0] rt_data_q;
  logic [WIDTH-1:0] imm_q;
  logic             alu_src_q;
  logic             mem_read_q;
  logic             reg_write_q;
  logic [RA_W-1:0]  dst_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic [RA_W-1:0]  id_dst;
  logic             id_reg_write_eff;
  logic             stall;
  logic [WIDTH-1:0] rs_fwd;
  logic [WIDTH-1:0] rt_fwd;

  function automatic logic [WIDTH-1:0] bypass(
    input logic [RA_W-1:0]  idx,
    input logic [WIDTH-1:0] reg_val,
    input logic             m_we,
    input logic [RA_W-1:0]  m_dst,
    input logic [WIDTH-1:0] m_data,
    input logic             w_we,
    input logic [RA_W-1:0]  w_dst,
    input logic [WIDTH-1:0] w_data
  );
    logic [WIDTH-1:0] r;
    r = reg_val;
    if (m_we && (m_dst != '0) && (m_dst == idx))
      r = m_data;
    else if (w_we && (w_dst != '0) && (w_dst == idx))
      r = w_data;
    return r;
  endfunction

  always_comb begin
    id_dst = bus.id_rt;
    case (bus.id_reg_dst)
      2'b01:   id_dst = bus.id_rd;
      2'b10:   id_dst = LINK_IDX;
      default: id_dst = bus.id_rt;
    endcase
    // register 0 is never a real write target
    id_reg_write_eff = bus.id_reg_write && (id_dst != '0);
  end

  always_comb begin
    stall = bus.id_valid && valid_q && mem_read_q && (dst_q != '0) &&
            ((bus.id_rs == dst_q) || (bus.id_rt == dst_q));
  end

  always_comb begin
    rs_fwd = bypass(rs_q, rs_data_q, bus.mem_reg_write, bus.mem_dst, bus.mem_data,
                    bus.wb_reg_write, bus.wb_dst, bus.wb_data);
    rt_fwd = bypass(rt_q, rt_data_q, bus.mem_reg_write, bus.mem_dst, bus.mem_data,
                    bus.wb_reg_write, bus.wb_dst, bus.wb_data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      alu_src_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      reg_write_q <= 1'b0;
      dst_q       <= '0;
    end else if (bus.flush || stall) begin
      // bubble: only valid drops, payload is don't-care while invalid
      valid_q <= 1'b0;
    end else begin
      valid_q     <= bus.id_valid;
      rs_q        <= bus.id_rs;
      rt_q        <= bus.id_rt;
      rs_data_q   <= bus.id_rs_data;
      rt_data_q   <= bus.id_rt_data;
      imm_q       <= bus.id_imm;
      alu_src_q   <= bus.id_alu_src;
      mem_read_q  <= bus.id_mem_read;
      reg_write_q <= id_reg_write_eff;
      dst_q       <= id_dst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_q <= '0;
    else if (stall && (stall_cnt_q != '1))
      stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  always_comb begin
    bus.ex_valid      = valid_q;
    bus.ex_op_a       = rs_fwd;
    bus.ex_op_b       = alu_src_q ? imm_q : rt_fwd;
    bus.ex_store_data = rt_fwd;
    bus.ex_dst        = dst_q;
    bus.ex_reg_write  = valid_q && reg_write_q;
    bus.ex_mem_read   = valid_q && mem_read_q;
    bus.stall         = stall;
    bus.stall_cnt     = stall_cnt_q;
  end

endmodule
